// File: rtl/dct_seq_pkg.sv
// Shared types and width helpers for the dct_unit MAC sequencer.
// Holds the sequencer state enum, default geometry and the counter width functions.
package dct_seq_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StMult,
        StDrain,
        StHold
    } seq_state_e;

    localparam int unsigned DefTaps = 8;
    localparam int unsigned DefRows = 8;

    function automatic int unsigned TAP_W(input int unsigned taps);
        return (taps > 1) ? $clog2(taps) : 1;
    endfunction

    function automatic int unsigned ROW_W(input int unsigned rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

endpackage

// File: rtl/dct_tap_counter.sv
// Modulo-N up counter with enable, synchronous clear and terminal-count flag.
// Used for both the tap index and the row index of the MAC sequencer.
module dct_tap_counter #(
    parameter int unsigned N = 8,
    parameter int unsigned W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tc_o  = (cnt_q == W'(N - 1));
    assign cnt_o = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tc_o ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dct_mac_sequencer.sv
// Control sequencer for one dct_unit MAC: TAPS multiply cycles, a drain cycle, then a
// valid/ready result hand-off; counts rows per block. DCT_MAC_SEQ_ROUND_EN enables round_o.
module dct_mac_sequencer
    import dct_seq_pkg::*;
#(
    parameter int unsigned TAPS = DefTaps,
    parameter int unsigned ROWS = DefRows
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ena,
    input  logic                     start_i,
    output logic                     ready_o,
    output logic [TAP_W(TAPS)-1:0]   tap_o,
    output logic                     mult_en_o,
    output logic                     acc_clr_o,
    output logic                     acc_en_o,
    output logic                     round_o,
    output logic                     dout_valid_o,
    input  logic                     dout_ready_i,
    output logic [ROW_W(ROWS)-1:0]   row_o,
    output logic                     block_done_o,
    output logic                     busy_o
);

    localparam int unsigned TW = TAP_W(TAPS);
    localparam int unsigned RW = ROW_W(ROWS);

    seq_state_e state_q, state_d;
    logic       acc_en_q, acc_en_d;
    logic       acc_clr_q, acc_clr_d;

    logic          tap_tc;
    logic          row_tc;
    logic [TW-1:0] tap_cnt;
    logic [RW-1:0] row_cnt;
    logic          handoff;
    logic          in_mult;

    assign in_mult = (state_q == StMult);
    assign handoff = ena && (state_q == StHold) && dout_ready_i;

    dct_tap_counter #(
        .N (TAPS),
        .W (TW)
    ) u_tap_cnt (
        .clk   (clk),
        .rst   (rst),
        .en_i  (ena && in_mult),
        .clr_i (ena && (state_q == StIdle)),
        .cnt_o (tap_cnt),
        .tc_o  (tap_tc)
    );

    dct_tap_counter #(
        .N (ROWS),
        .W (RW)
    ) u_row_cnt (
        .clk   (clk),
        .rst   (rst),
        .en_i  (handoff),
        .clr_i (1'b0),
        .cnt_o (row_cnt),
        .tc_o  (row_tc)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (ena && start_i) state_d = StMult;
            StMult:  if (ena && tap_tc) state_d = StDrain;
            StDrain: if (ena) state_d = StHold;
            StHold:  if (handoff) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Accumulator strobes trail the multiplier register by one cycle.
    always_comb begin
        acc_en_d  = acc_en_q;
        acc_clr_d = acc_clr_q;
        if (ena) begin
            acc_en_d  = in_mult;
            acc_clr_d = in_mult && (tap_cnt == '0);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            acc_en_q  <= 1'b0;
            acc_clr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_en_q  <= acc_en_d;
            acc_clr_q <= acc_clr_d;
        end
    end

`ifdef DCT_MAC_SEQ_ROUND_EN
    logic round_q, round_d;

    always_comb begin
        round_d = round_q;
        if (ena) begin
            round_d = in_mult && tap_tc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            round_q <= 1'b0;
        end else begin
            round_q <= round_d;
        end
    end

    assign round_o = round_q && ena;
`else
    assign round_o = 1'b0;
`endif

    // Gating with ena keeps a frozen cycle from capturing or accumulating twice.
    assign mult_en_o    = in_mult && ena;
    assign acc_en_o     = acc_en_q && ena;
    assign acc_clr_o    = acc_clr_q && ena;
    assign tap_o        = tap_cnt;
    assign row_o        = row_cnt;
    assign ready_o      = (state_q == StIdle);
    assign busy_o       = (state_q != StIdle);
    assign dout_valid_o = (state_q == StHold);
    assign block_done_o = handoff && row_tc;

endmodule

// File: tb/tb_dct_mac_sequencer.sv
// Self-checking bench for dct_mac_sequencer: directed scenarios plus randomized traffic
// compared each cycle against a row-phase reference model.
module tb_dct_mac_sequencer;

    localparam int unsigned TAPS = 8;
    localparam int unsigned ROWS = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic       start_i;
    logic       ready_o;
    logic [2:0] tap_o;
    logic       mult_en_o;
    logic       acc_clr_o;
    logic       acc_en_o;
    logic       round_o;
    logic       dout_valid_o;
    logic       dout_ready_i;
    logic [2:0] row_o;
    logic       block_done_o;
    logic       busy_o;

    dct_mac_sequencer #(
        .TAPS (TAPS),
        .ROWS (ROWS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ena          (ena),
        .start_i      (start_i),
        .ready_o      (ready_o),
        .tap_o        (tap_o),
        .mult_en_o    (mult_en_o),
        .acc_clr_o    (acc_clr_o),
        .acc_en_o     (acc_en_o),
        .round_o      (round_o),
        .dout_valid_o (dout_valid_o),
        .dout_ready_i (dout_ready_i),
        .row_o        (row_o),
        .block_done_o (block_done_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: m_k is the cycle number within the row (1 = first MULT cycle).
    bit m_busy;
    int m_k;
    int m_row;
    int acc_seen;
    int done_seen;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy   = 1'b0;
        m_k      = 0;
        m_row    = 0;
        acc_seen = 0;
    endtask

    task automatic compare_outputs();
        bit e_mult, e_acc, e_clr, e_round, e_valid, e_done;
        int e_tap;
        e_tap   = (m_busy && m_k <= TAPS) ? m_k - 1 : 0;
        e_mult  = ena && m_busy && (m_k <= TAPS);
        e_acc   = ena && m_busy && (m_k >= 2) && (m_k <= TAPS + 1);
        e_clr   = ena && m_busy && (m_k == 2);
`ifdef DCT_MAC_SEQ_ROUND_EN
        e_round = ena && m_busy && (m_k == TAPS + 1);
`else
        e_round = 1'b0;
`endif
        e_valid = m_busy && (m_k == TAPS + 2);
        e_done  = ena && rst && e_valid && dout_ready_i && (m_row == ROWS - 1);
        check_eq("ready", 32'(ready_o), 32'(!m_busy));
        check_eq("busy", 32'(busy_o), 32'(m_busy));
        check_eq("tap", 32'(tap_o), 32'(e_tap));
        check_eq("mult_en", 32'(mult_en_o), 32'(e_mult));
        check_eq("acc_en", 32'(acc_en_o), 32'(e_acc));
        check_eq("acc_clr", 32'(acc_clr_o), 32'(e_clr));
        check_eq("round", 32'(round_o), 32'(e_round));
        check_eq("dout_valid", 32'(dout_valid_o), 32'(e_valid));
        check_eq("row", 32'(row_o), 32'(m_row));
        check_eq("block_done", 32'(block_done_o), 32'(e_done));
        if (acc_en_o === 1'b1) acc_seen++;
        if (block_done_o === 1'b1) done_seen++;
    endtask

    task automatic advance();
        if (!rst) begin
            model_reset();
        end else if (ena) begin
            if (!m_busy) begin
                if (start_i) begin
                    m_busy = 1'b1;
                    m_k    = 1;
                end
            end else if (m_k < TAPS + 2) begin
                m_k++;
            end else if (dout_ready_i) begin
                check_eq("acc_per_row", 32'(acc_seen), 32'(TAPS));
                acc_seen = 0;
                m_busy   = 1'b0;
                m_k      = 0;
                m_row    = (m_row + 1) % ROWS;
            end
        end
    endtask

    task automatic cyc(input logic s, input logic e, input logic r);
        @(negedge clk);
        start_i      = s;
        ena          = e;
        dout_ready_i = r;
        #1;
        compare_outputs();
        @(posedge clk);
        advance();
    endtask

    // Reset lands 2 time units after a falling edge, well away from the rising edge.
    task automatic async_reset();
        @(negedge clk);
        start_i = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        compare_outputs();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst          = 1'b0;
        ena          = 1'b1;
        start_i      = 1'b0;
        dout_ready_i = 1'b1;
        done_seen    = 0;
        model_reset();
        #3;
        compare_outputs();
        @(negedge clk);
        rst = 1'b1;

        // Single row with the consumer always ready.
        cyc(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 11; i++) cyc(1'b0, 1'b1, 1'b1);
        check_eq("row_after_first", 32'(row_o), 32'd1);

        // Stall in HOLD with start pulses, then a start coincident with the hand-off.
        cyc(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) cyc(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'(i % 2), 1'b1, 1'b0);
        check_eq("stall_valid", 32'(dout_valid_o), 32'd1);
        cyc(1'b1, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b1);
        check_eq("no_queued_start", 32'(busy_o), 32'd0);

        // Full block of back-to-back rows from row 0.
        async_reset();
        done_seen = 0;
        for (int r = 0; r < ROWS; r++) begin
            cyc(1'b1, 1'b1, 1'b1);
            for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 1'b1);
        end
        check_eq("block_done_count", 32'(done_seen), 32'd1);

        // Clock-enable freeze while tap_o is 3.
        cyc(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 1'b1);
            check_eq("freeze_tap", 32'(tap_o), 32'd3);
        end
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 1'b1);

        // Asynchronous reset while tap_o is 5, then a clean row.
        cyc(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b1);
        async_reset();
        check_eq("rst_row", 32'(row_o), 32'd0);
        cyc(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 1'b1);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                async_reset();
            end else begin
                cyc(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 9) != 0),
                    1'($urandom_range(0, 2) != 0));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dct_mac_sequencer.md
Name: dct_mac_sequencer

Overview:
Control sequencer for one fdct dct_unit MAC (multiplier + mult_res register + accumulator) inside dct_block.
- Each accepted row start runs TAPS multiply cycles, then drains the multiplier-register pipeline and presents one accumulated result with a valid/ready handshake.
- Counts rows so the enclosing dct_block knows when an 8x8 block is complete.

Parameters:
- TAPS, 8: MAC taps per row result; must be a power of two, ≥2.
- ROWS, 8: rows per block; must be a power of two, ≥2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active low.
- ena  in  1  global clock enable; 0 freezes all state.
- start_i  in  1  row start request.
- ready_o  out  1  sequencer can accept start_i.
- tap_o  out  $clog2(TAPS)  coefficient/sample select for the current tap.
- mult_en_o  out  1  enable for the mult_res register.
- acc_clr_o  out  1  load the accumulator with the product instead of adding.
- acc_en_o  out  1  accumulator enable.
- round_o  out  1  add the rounding constant on the final accumulate.
- dout_valid_o  out  1  accumulator result valid.
- dout_ready_i  in  1  downstream accepts the result.
- row_o  out  $clog2(ROWS)  index of the current row.
- block_done_o  out  1  one-cycle pulse when the last row is handed off.
- busy_o  out  1  sequencer is not in IDLE.

Behaviour:
- Reset (rst=0, async): state=IDLE, tap/row counters=0, all strobes 0, dout_valid_o=0. ready_o=1 after reset release.
- All registers update only when ena=1. mult_en_o and acc_en_o are registered values ANDed with ena, so a frozen cycle never double-captures or double-accumulates.
- FSM states:
  - IDLE: ready_o=1. start_i=1 → MULT with tap=0.
  - MULT: mult_en_o=1, tap_o = tap counter. The counter increments each cycle. At tap=TAPS-1 → DRAIN.
  - DRAIN: one cycle, completes the final accumulate → HOLD.
  - HOLD: dout_valid_o=1. Result handed off (dout_valid_o & dout_ready_i) → IDLE.
- Pipeline alignment: acc_en_o is mult_en_o delayed one cycle, so it is high from cycle 2 through cycle TAPS+1. acc_clr_o is high only with the first acc_en_o. round_o is high only with the last acc_en_o (see Optional Feature).
- Timing, TAPS=8, start accepted at edge 0:
  - cycles 1-8: MULT, tap_o=0..7.
  - cycle 2: acc_clr_o=1.
  - cycle 9: DRAIN, last acc_en_o.
  - cycle 10: dout_valid_o=1.
  - Minimum 11 cycles per row with dout_ready_i held high.
- Handshake:
  - dout_valid_o holds until accepted and never drops without a handoff.
  - start_i is ignored (not queued) while busy_o=1.
- Row counting:
  - row_o increments on each handoff and wraps ROWS-1 → 0.
  - block_done_o pulses for the handoff cycle that performs the wrap.
- Simultaneous events: start_i asserted in the same cycle as a HOLD handoff is ignored; it must be re-presented in IDLE.
- Reset mid-operation: abandon the row immediately. row_o=0, no block_done_o, no dout_valid_o.

Optional Feature:
- Macro: DCT_MAC_SEQ_ROUND_EN.
- Defined: round_o=1 coincident with the final acc_en_o of each row (the DRAIN cycle).
- Undefined: round_o is tied to 0. The port is still present and all other timing is identical.

Decomposition:
- Package dct_seq_pkg holds:
  - the state enum (IDLE, MULT, DRAIN, HOLD);
  - default TAPS and ROWS localparams;
  - the TAP_W and ROW_W width functions.
- One sub-module, dct_tap_counter: a modulo-N counter with enable, synchronous clear and terminal-count output. It is instantiated twice, for the tap counter and the row counter.

Test Plan:
- Reset, then one start with dout_ready_i=1 → tap_o 0..7 in cycles 1-8; acc_clr_o only in cycle 2; acc_en_o in cycles 2-9; dout_valid_o in cycle 10; row_o 0→1.
- Hold dout_ready_i=0 for 5 cycles in HOLD → dout_valid_o stays 1, row_o unchanged, start_i pulses ignored. Release → exactly one handoff.
- Eight back-to-back rows → block_done_o pulses once on the 8th handoff, row_o returns to 0.
- Toggle ena=0 for 3 cycles mid-MULT at tap=3 → tap_o frozen at 3, mult_en_o/acc_en_o low, no extra acc_en_o; total acc_en_o count stays 8.
- Assert rst=0 asynchronously at tap=5 → all outputs 0 immediately, state IDLE, row_o=0. The next start runs a clean row.
- With DCT_MAC_SEQ_ROUND_EN defined → round_o=1 only in cycle 9. Undefined → round_o stays 0 throughout.
